// File: rtl/bus_addr_router.sv
// Single-master to N-slave request router with BASE/MASK decode, one outstanding
// transaction, and generated error responses for unmapped addresses and slave timeouts.
module bus_addr_router #(
    parameter int unsigned                N_SLAVES    = 4,
    parameter int unsigned                XLEN        = 32,
    parameter logic [N_SLAVES*XLEN-1:0]   SLV_BASE    = {32'h6000_0000, 32'h4000_0000,
                                                         32'h2000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*XLEN-1:0]   SLV_MASK    = {4{32'hF000_0000}},
    parameter int unsigned                TIMEOUT_CYC = 255,
    parameter logic [XLEN-1:0]            ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_req_valid,
    output logic                     m_req_ready,
    input  logic [XLEN-1:0]          m_req_addr,
    input  logic                     m_req_we,
    input  logic [XLEN-1:0]          m_req_wdata,
    input  logic [XLEN/8-1:0]        m_req_be,
    output logic                     m_rsp_valid,
    input  logic                     m_rsp_ready,
    output logic [XLEN-1:0]          m_rsp_rdata,
    output logic                     m_rsp_err,
    output logic [N_SLAVES-1:0]      s_req_valid,
    input  logic [N_SLAVES-1:0]      s_req_ready,
    output logic [XLEN-1:0]          s_req_addr,
    output logic                     s_req_we,
    output logic [XLEN-1:0]          s_req_wdata,
    output logic [XLEN/8-1:0]        s_req_be,
    input  logic [N_SLAVES-1:0]      s_rsp_valid,
    output logic [N_SLAVES-1:0]      s_rsp_ready,
    input  logic [N_SLAVES*XLEN-1:0] s_rsp_rdata,
    input  logic [N_SLAVES-1:0]      s_rsp_err,
    output logic                     dec_err,
    output logic                     tmo_err,
    output logic [15:0]              err_cnt
);

    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StErr} state_e;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q;
    logic [XLEN-1:0]       addr_q, wdata_q;
    logic                  we_q;
    logic [XLEN/8-1:0]     be_q;
    logic [CNT_W-1:0]      tmo_cnt_q;
    logic                  dec_err_q, tmo_err_q;
    logic [15:0]           err_cnt_q;

    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_sel;
    logic                  tmo_hit, rsp_hs, dec_set, tmo_set;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_req_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC));
    assign rsp_hs  = s_rsp_valid[sel_q] & m_rsp_ready;
    assign dec_set = (state_q == StIdle) && m_req_valid && !dec_hit;
    // A response handshake in the timeout cycle takes priority over the abort.
    assign tmo_set = ((state_q == StIssue) || (state_q == StWait && !rsp_hs)) && tmo_hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (m_req_valid) state_d = dec_hit ? StIssue : StErr;
            StIssue: begin
                if (tmo_hit)                 state_d = StErr;
                else if (s_req_ready[sel_q]) state_d = StWait;
            end
            StWait: begin
                if (rsp_hs)       state_d = StIdle;
                else if (tmo_hit) state_d = StErr;
            end
            StErr:   if (m_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            tmo_cnt_q <= '0;
            dec_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dec_err_q <= dec_set;
            tmo_err_q <= tmo_set;
            if (state_q == StIdle && m_req_valid) begin
                sel_q   <= dec_sel;
                addr_q  <= m_req_addr;
                we_q    <= m_req_we;
                wdata_q <= m_req_wdata;
                be_q    <= m_req_be;
            end
            if (state_q == StIssue || state_q == StWait) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
            if ((dec_set || tmo_set) && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        m_req_ready = (state_q == StIdle);
        s_req_valid = '0;
        s_rsp_ready = '1;
        m_rsp_valid = 1'b0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        unique case (state_q)
            StIssue: s_req_valid[sel_q] = 1'b1;
            StWait: begin
                m_rsp_valid        = s_rsp_valid[sel_q];
                m_rsp_rdata        = s_rsp_rdata[sel_q*XLEN +: XLEN];
                m_rsp_err          = s_rsp_err[sel_q];
                s_rsp_ready[sel_q] = m_rsp_ready;
            end
            StErr: begin
                m_rsp_valid = 1'b1;
                m_rsp_rdata = ERR_RDATA;
                m_rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_req_addr  = addr_q;
    assign s_req_we    = we_q;
    assign s_req_wdata = wdata_q;
    assign s_req_be    = be_q;
    assign dec_err     = dec_err_q;
    assign tmo_err     = tmo_err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_bus_addr_router.sv
// Randomised bench for bus_addr_router: the bench plays master and all slaves from a
// per-transaction cycle schedule and checks every cycle against a decode/timeout model.
module tb_bus_addr_router;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req_valid, m_req_ready, m_req_we;
    logic [31:0]  m_req_addr, m_req_wdata;
    logic [3:0]   m_req_be;
    logic         m_rsp_valid, m_rsp_ready, m_rsp_err;
    logic [31:0]  m_rsp_rdata;
    logic [3:0]   s_req_valid, s_req_ready, s_req_be;
    logic [31:0]  s_req_addr, s_req_wdata;
    logic         s_req_we;
    logic [3:0]   s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [127:0] s_rsp_rdata;
    logic         dec_err, tmo_err;
    logic [15:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt_m = 0;

    // Slave 0 and slave 3 share a region; slave 2 sits at address zero.
    logic [31:0] base_m [4] = '{32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 32'h4000_0000};

    bus_addr_router #(
        .N_SLAVES   (4),
        .XLEN       (32),
        .SLV_BASE   ({32'h4000_0000, 32'h0000_0000, 32'h2000_0000, 32'h4000_0000}),
        .SLV_MASK   ({4{32'hF000_0000}}),
        .TIMEOUT_CYC(TMO),
        .ERR_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready),
        .m_req_addr (m_req_addr),
        .m_req_we   (m_req_we),
        .m_req_wdata(m_req_wdata),
        .m_req_be   (m_req_be),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_ready(m_rsp_ready),
        .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err  (m_rsp_err),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_req_addr (s_req_addr),
        .s_req_we   (s_req_we),
        .s_req_wdata(s_req_wdata),
        .s_req_be   (s_req_be),
        .s_rsp_valid(s_rsp_valid),
        .s_rsp_ready(s_rsp_ready),
        .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err  (s_rsp_err),
        .dec_err    (dec_err),
        .tmo_err    (tmo_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_target(input logic [31:0] a);
        int r = -1;
        for (int i = 3; i >= 0; i--) begin
            if ((a & 32'hF000_0000) == base_m[i]) r = i;
        end
        return r;
    endfunction

    task automatic drive_noise();
        s_req_ready = 4'($urandom);
        s_rsp_valid = 4'($urandom);
        s_rsp_err   = 4'($urandom);
        s_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
        m_rsp_ready = 1'($urandom);
    endtask

    task automatic check_reset_outputs();
        check("rst_m_req_ready", 32'(m_req_ready), 32'd1);
        check("rst_s_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("rst_m_rsp_err", 32'(m_rsp_err), 32'd0);
        check("rst_m_rsp_rdata", m_rsp_rdata, 32'd0);
        check("rst_dec_err", 32'(dec_err), 32'd0);
        check("rst_tmo_err", 32'(tmo_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_s_req_addr", s_req_addr, 32'd0);
        check("rst_s_req_wdata", s_req_wdata, 32'd0);
        check("rst_s_req_ctl", {27'd0, s_req_we, s_req_be}, 32'd0);
    endtask

    // Error response phase (miss or timeout): master holds off for 'hold' cycles.
    task automatic err_phase(input string kind, input int hold);
        for (int h = 0; h <= hold; h++) begin
            drive_noise();
            m_rsp_ready = (h == hold);
            #1;
            check({kind, "_pulse"}, 32'(kind == "dec" ? dec_err : tmo_err), 32'(h == 0));
            check({kind, "_other_pulse"}, 32'(kind == "dec" ? tmo_err : dec_err), 32'd0);
            check({kind, "_rsp_valid"}, 32'(m_rsp_valid), 32'd1);
            check({kind, "_rsp_rdata"}, m_rsp_rdata, 32'hDEAD_BEEF);
            check({kind, "_rsp_err"}, 32'(m_rsp_err), 32'd1);
            check({kind, "_s_req_valid"}, 32'(s_req_valid), 32'd0);
            check({kind, "_s_rsp_ready"}, 32'(s_rsp_ready), 32'hF);
            check({kind, "_m_req_ready"}, 32'(m_req_ready), 32'd0);
            tick();
        end
        err_cnt_m++;
    endtask

    // One full transaction. Timeline index t counts cycles from the first ISSUE cycle:
    // slave accepts at t=rdy_lat, responds from t=rdy_lat+1+rsp_lat, master takes it
    // 'hold' cycles later. A handshake later than t=TMO means a timeout at t=TMO.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] be, input int rdy_lat, input int rsp_lat,
                           input int hold, input logic [31:0] rdata, input logic rerr,
                           input int rst_at);
        int tgt = ref_target(addr);
        int t_rsp = rdy_lat + 1 + rsp_lat;
        int t_hs = t_rsp + hold;
        int t_end = (t_hs <= TMO) ? t_hs : TMO;
        bit aborted = 1'b0;
        logic [3:0] oh, exp_sr;
        bit in_issue, exp_mv;

        drive_noise();
        m_req_valid = 1'b1;
        m_req_addr  = addr;
        m_req_we    = we;
        m_req_wdata = wdata;
        m_req_be    = be;
        #1;
        check("idle_m_req_ready", 32'(m_req_ready), 32'd1);
        tick();
        m_req_valid = 1'b0;
        m_req_addr  = $urandom;
        m_req_wdata = $urandom;
        m_req_we    = ~we;
        m_req_be    = ~be;

        if (tgt < 0) begin
            err_phase("dec", hold);
        end else begin
            oh = 4'd1 << tgt;
            for (int t = 0; t <= t_end; t++) begin
                in_issue = (t <= rdy_lat);
                exp_mv = !in_issue && (t >= t_rsp);
                drive_noise();
                if (in_issue) s_req_ready[tgt] = (t == rdy_lat);
                else s_rsp_valid[tgt] = (t >= t_rsp);
                if (exp_mv) begin
                    m_rsp_ready = (t >= t_hs);
                    s_rsp_rdata[tgt*32 +: 32] = rdata;
                    s_rsp_err[tgt] = rerr;
                end
                #1;
                exp_sr = 4'hF;
                if (!in_issue) exp_sr[tgt] = m_rsp_ready;
                check("s_req_valid", 32'(s_req_valid), in_issue ? 32'(oh) : 32'd0);
                check("s_req_addr", s_req_addr, addr);
                check("s_req_wdata", s_req_wdata, wdata);
                check("s_req_we_be", {27'd0, s_req_we, s_req_be}, {27'd0, we, be});
                check("busy_m_req_ready", 32'(m_req_ready), 32'd0);
                check("m_rsp_valid", 32'(m_rsp_valid), 32'(exp_mv));
                if (exp_mv) begin
                    check("m_rsp_rdata", m_rsp_rdata, rdata);
                    check("m_rsp_err", 32'(m_rsp_err), 32'(rerr));
                end
                check("s_rsp_ready", 32'(s_rsp_ready), 32'(exp_sr));
                check("busy_err_pulses", {30'd0, dec_err, tmo_err}, 32'd0);
                if (t == rst_at) begin
                    rst = 1'b1;
                    #1;
                    err_cnt_m = 0;
                    check_reset_outputs();
                    tick();
                    rst = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                tick();
            end
            if (!aborted && t_hs > TMO) err_phase("tmo", 1);
        end
        if (!aborted) begin
            m_req_valid = 1'b0;
            #1;
            check("done_m_req_ready", 32'(m_req_ready), 32'd1);
            check("err_cnt", 32'(err_cnt), 32'(err_cnt_m));
        end
    endtask

    initial begin
        logic [3:0] nib [8] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h4, 4'h4, 4'h6, 4'h8};
        logic [31:0] a;
        int rl;

        rst = 1'b1;
        m_req_valid = 1'b0;
        m_req_addr = '0;
        m_req_we = 1'b0;
        m_req_wdata = '0;
        m_req_be = '0;
        drive_noise();
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();

        run_txn(32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 1, 0, 32'h1234_5678, 1'b0, -1);
        run_txn(32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'h3, 0, 0, 0, 32'h0, 1'b0, -1);
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 1000, 0, 32'h0, 1'b0, -1);

        // Late response from the timed-out slave must be sunk.
        for (int i = 0; i < 3; i++) begin
            drive_noise();
            s_rsp_valid = 4'b0100;
            s_rsp_rdata[64 +: 32] = 32'hBAD0_0002;
            #1;
            check("late_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
            check("late_s_rsp_ready", 32'(s_rsp_ready), 32'hF);
            check("late_m_req_ready", 32'(m_req_ready), 32'd1);
            tick();
        end

        run_txn(32'h4000_0020, 1'b0, 32'h0, 4'hF, 1, 0, 5, 32'hA5A5_0000, 1'b1, -1);
        run_txn(32'h2000_0040, 1'b1, 32'h1111_2222, 4'h1, 2, 3, 2, 32'h7777_0000, 1'b0, -1);
        run_txn(32'h0000_0200, 1'b1, 32'h3333_4444, 4'h8, 20, 0, 0, 32'h0, 1'b0, -1);
        run_txn(32'h4000_0004, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h0BAD_CAFE, 1'b0, -1);
        run_txn(32'h6000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 3, 32'h0, 1'b0, -1);
        run_txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 5, 0, 32'h0, 1'b0, 1);
        run_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h5555_AAAA, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            a = {nib[$urandom_range(0, 7)], 28'($urandom)};
            rl = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, 3));
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)), rl,
                    int'($urandom_range(0, 3)), $urandom, 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
